// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game: timer state encoding and default
// counter width, used by tick_timer and by the game FSM.
package simon_pkg;

    // Default width of timer duration / remaining count.
    localparam int TIMER_CNT_WIDTH = 8;

    // Timer control states.
    typedef enum logic {
        TIMER_IDLE = 1'b0,
        TIMER_RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/tick_timer.sv
// Tick-driven countdown timer. It loads a duration on start and counts
// divider ticks down to expiry. At expiry it emits a one-cycle done pulse,
// and then either returns to IDLE (one-shot) or reloads itself (periodic).
module tick_timer
    import simon_pkg::*;
#(
    parameter int CNT_WIDTH = TIMER_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 periodic,
    input  logic [CNT_WIDTH-1:0] duration,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] remaining
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    timer_state_t         state;
    logic [CNT_WIDTH-1:0] dur_latched;
    logic                 per_latched;

    // busy reflects the registered state directly, so it falls in the same cycle done rises
    assign busy = (state == TIMER_RUN);

    // Timer FSM: abort wins over everything, start is honoured only in IDLE, ticks only in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= TIMER_IDLE;
            done        <= 1'b0;
            remaining   <= CNT_ZERO;
            dur_latched <= CNT_ZERO;
            per_latched <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= TIMER_IDLE;
                remaining <= CNT_ZERO;
            end else begin
                case (state)
                    TIMER_IDLE: begin
                        if (start) begin
                            if (duration != CNT_ZERO) begin
                                // A tick coinciding with the load is not counted
                                state       <= TIMER_RUN;
                                remaining   <= duration;
                                dur_latched <= duration;
                                per_latched <= periodic;
                            end else begin
                                // Zero-length request expires immediately without running
                                done <= 1'b1;
                            end
                        end
                    end
                    TIMER_RUN: begin
                        if (tick) begin
                            if (remaining > CNT_ONE) begin
                                remaining <= remaining - CNT_ONE;
                            end else begin
                                // Expiry: covers remaining==1, and also recovers safely from 0
                                done <= 1'b1;
                                if (per_latched) begin
                                    remaining <= dur_latched;
                                end else begin
                                    state     <= TIMER_IDLE;
                                    remaining <= CNT_ZERO;
                                end
                            end
                        end
                    end
                    default: begin
                        state     <= TIMER_IDLE;
                        remaining <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

endmodule
